// File: rtl/io_register_block.sv
// Memory-mapped LED / seven-segment / button peripheral for the ulisp register bus.
// Buttons are synchronised, debounced and reported as sticky rising-edge events (clear-on-read).
module io_register_block #(
  parameter int NUM_DIGITS      = 4,
  parameter int NUM_BUTTONS     = 4,
  parameter int LED_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LED_INDEX       = 1,
  parameter int DIGIT_BASE      = 2,
  parameter int BUTTON_INDEX    = 6,
  parameter int EVENT_INDEX     = 7,
  parameter int MODE_INDEX      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              register_index,
  input  logic                    register_read,
  input  logic                    register_write,
  input  logic [15:0]             register_write_value,
  output logic [15:0]             register_read_value,
  input  logic [NUM_BUTTONS-1:0]  buttons,
  output logic [LED_WIDTH-1:0]    led,
  output logic [7*NUM_DIGITS-1:0] segments
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [6:0]             digit_store [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  mode;
  logic [NUM_BUTTONS-1:0] sync1, sync2, debounced, events;
  logic [NUM_BUTTONS-1:0] accept, rise;
  logic [CNT_W-1:0]       cnt [NUM_BUTTONS];
  logic [15:0]            read_mux;
  logic                   event_clear;
  logic                   unused_write_bits;

  assign unused_write_bits = ^register_write_value;
  assign event_clear = register_read && (register_index == 7'(EVENT_INDEX));

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'h3F;  4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;  4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;  4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;  4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;  4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;  4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;  4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;  default: hex_decode = 7'h71;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led  <= '0;
      mode <= '0;
      // NOTE: the digit stores are an array but still need an explicit reset, element by element.
      for (int d = 0; d < NUM_DIGITS; d++) digit_store[d] <= '0;
    end else if (register_write) begin
      if (register_index == 7'(LED_INDEX))  led  <= register_write_value[LED_WIDTH-1:0];
      if (register_index == 7'(MODE_INDEX)) mode <= register_write_value[NUM_DIGITS-1:0];
      for (int d = 0; d < NUM_DIGITS; d++)
        if (register_index == 7'(DIGIT_BASE + d)) digit_store[d] <= register_write_value[6:0];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    segments = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      segments[7*d +: 7] = mode[d] ? hex_decode(digit_store[d][3:0]) : digit_store[d];
  end

  // A change is accepted on the cycle the counter has already seen DEBOUNCE_CYCLES-1 differing cycles.
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      accept[b] = (sync2[b] != debounced[b]) && (cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1));
      rise[b]   = accept[b] && sync2[b];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      debounced <= '0;
      for (int b = 0; b < NUM_BUTTONS; b++) cnt[b] <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        if (accept[b]) begin
          debounced[b] <= sync2[b];
          cnt[b]       <= '0;
        end else if (sync2[b] != debounced[b]) begin
          cnt[b] <= cnt[b] + CNT_W'(1);
        end else begin
          cnt[b] <= '0;
        end
      end
    end
  end

  // A clearing read drops every returned bit, but a rise in the same cycle still lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            events <= '0;
    else if (event_clear) events <= rise;
    else                  events <= events | rise;
  end

  always_comb begin
    read_mux = '0;
    if (register_index == 7'(LED_INDEX))    read_mux = 16'(led);
    if (register_index == 7'(MODE_INDEX))   read_mux = 16'(mode);
    if (register_index == 7'(BUTTON_INDEX)) read_mux = 16'(debounced);
    if (register_index == 7'(EVENT_INDEX))  read_mux = 16'(events);
    for (int d = 0; d < NUM_DIGITS; d++)
      if (register_index == 7'(DIGIT_BASE + d)) read_mux = 16'(digit_store[d]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              register_read_value <= '0;
    else if (register_read) register_read_value <= read_mux;
  end

endmodule
